// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Stall/flush sequencer for the 5-stage RV32I pipeline. It drives the load
//   enables and flush strobes of the pipeline registers and the PC load enable.
//   It resolves three conditions: memory wait, load-use hazard and taken
//   redirect. It also keeps performance counters and a sticky stall watchdog.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   imem_resp           fetch data valid this cycle
//   dmem_req/dmem_resp  MEM-stage access present / completing this cycle
//   id_rs1/2, id_use_rs1/2, ex_rd, ex_is_load   load-use hazard inputs
//   redirect            taken branch/jump resolved this cycle
//   *_load, *_flush     pipeline register load enables and NOP-insert strobes
//   stall_cnt, bubble_cnt, flush_cnt   wrapping performance counters
//   stall_timeout       sticky watchdog flag for long memory stalls
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             redirect,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             id_ex_load,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_timeout
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [RUN_W-1:0] RUN_ONE = 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_redirect_pend;
  logic             w_pend_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [RUN_W-1:0] r_stall_run;
  logic [RUN_W-1:0] w_run_nxt;
  logic             r_stall_timeout;

  logic w_mem_stall;
  logic w_load_use;
  logic w_redir_eff;
  logic w_inc_stall;
  logic w_inc_flush;
  logic w_inc_bubble;

  assign w_mem_stall = !imem_resp | (dmem_req & !dmem_resp);
  assign w_load_use  = ex_is_load & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) |
                        (id_use_rs2 & (id_rs2 == ex_rd)));
  assign w_redir_eff = redirect | r_redirect_pend;

  // Saturating consecutive-stall count; any non-stall cycle restarts it.
  always_comb begin
    w_run_nxt = '0;
    if (w_mem_stall) begin
      w_run_nxt = (r_stall_run == RUN_MAX) ? r_stall_run : r_stall_run + RUN_ONE;
    end
  end

  // Next state and outputs. The release cycle out of WAIT is decoded exactly
  // like a RUN cycle, so both states share the same priority chain.
  always_comb begin
    w_state_nxt  = r_state;
    w_pend_nxt   = r_redirect_pend;
    pc_load      = 1'b0;
    if_id_load   = 1'b0;
    id_ex_load   = 1'b0;
    ex_mem_load  = 1'b0;
    mem_wb_load  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    w_inc_stall  = 1'b0;
    w_inc_flush  = 1'b0;
    w_inc_bubble = 1'b0;

    if (!rst) begin
      case (r_state)
        ST_RUN:  w_state_nxt = w_mem_stall ? ST_WAIT : ST_RUN;
        ST_WAIT: w_state_nxt = w_mem_stall ? ST_WAIT : ST_RUN;
        default: w_state_nxt = ST_RUN;
      endcase

      if (w_mem_stall) begin
        // Freeze everything; remember a redirect so it lands on release.
        w_inc_stall = 1'b1;
        if (redirect) w_pend_nxt = 1'b1;
      end else if (w_redir_eff) begin
        // Squash IF/ID, ID/EX, EX/MEM. Any load-use in ID is moot.
        pc_load      = 1'b1;
        if_id_load   = 1'b1;
        id_ex_load   = 1'b1;
        ex_mem_load  = 1'b1;
        mem_wb_load  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        w_pend_nxt   = 1'b0;
        w_inc_flush  = 1'b1;
      end else if (w_load_use) begin
        // Hold PC and IF/ID, inject a bubble into EX.
        id_ex_load   = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_load  = 1'b1;
        mem_wb_load  = 1'b1;
        w_inc_bubble = 1'b1;
      end else begin
        pc_load      = 1'b1;
        if_id_load   = 1'b1;
        id_ex_load   = 1'b1;
        ex_mem_load  = 1'b1;
        mem_wb_load  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_RUN;
      r_redirect_pend <= 1'b0;
      r_stall_cnt     <= '0;
      r_bubble_cnt    <= '0;
      r_flush_cnt     <= '0;
      r_stall_run     <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_redirect_pend <= w_pend_nxt;
      r_stall_run     <= w_run_nxt;
      if (w_inc_stall)  r_stall_cnt  <= r_stall_cnt + CNT_ONE;
      if (w_inc_bubble) r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      if (w_inc_flush)  r_flush_cnt  <= r_flush_cnt + CNT_ONE;
      if (w_mem_stall && (w_run_nxt == RUN_MAX)) r_stall_timeout <= 1'b1;
    end
  end

  assign stall_cnt     = r_stall_cnt;
  assign bubble_cnt    = r_bubble_cnt;
  assign flush_cnt     = r_flush_cnt;
  assign stall_timeout = r_stall_timeout;

endmodule
